riscv_id_stage: RTL and testbench

Parameterised decode stage for the pipelined RV32I/RV32E core. It contains the register file with write-back bypass, the control unit, the immediate decoder, and the ID/EX pipeline register with a valid/ready handshake. Internal load-use hazard detection inserts bubbles. An EX-stage flush kills the instruction being decoded. A stall counter records how many cycles the stage stalled. It sits between the IF/ID register and the execute stage.

---
 rtl/riscv_id_stage_pkg.sv | 53 +++++
 rtl/riscv_id_control.sv | 67 ++++++
 rtl/riscv_id_hazard.sv | 26 ++
 rtl/riscv_id_regfile.sv | 47 ++++
 rtl/riscv_id_stage.sv | 116 +++++++++++
 tb/tb_riscv_id_stage.sv | 241 ++++++++++++++++++++++++
 6 files changed

// File: rtl/riscv_id_stage_pkg.sv
// rtl/riscv_id_stage_pkg.sv - shared opcodes, control-bundle layout and format decode for the ID stage
package riscv_id_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  // Packed MSB-first so that reg_write lands on bit 0 and rd_src on bit 16.
  typedef struct packed {
    logic       rd_src;
    logic       alu_b_src;
    logic [3:0] byte_sel;
    logic [3:0] alu_control;
    logic       branch;
    logic [1:0] jump;
    logic       mem_write;
    logic [1:0] result_src;
    logic       reg_write;
  } ctrl_t;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_e;

  function automatic fmt_e op_format(input logic [6:0] op);
    case (op)
      OP_OP:                                         return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: return FMT_I;
      OP_STORE:                                      return FMT_S;
      OP_BRANCH:                                     return FMT_B;
      OP_LUI, OP_AUIPC:                              return FMT_U;
      OP_JAL:                                        return FMT_J;
      default:                                       return FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/riscv_id_control.sv
// rtl/riscv_id_control.sv - control unit and immediate decoder with illegal-instruction gating
module riscv_id_control
  import riscv_id_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [2:0]  f3;
  logic [31:0] imm32;

  assign f3 = instr[14:12];

  always_comb begin
    imm32 = '0;
    case (op_format(instr[6:0]))
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = XLEN'($signed(imm32));
  end

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (instr[6:0])
      OP_LUI:    begin ctrl.reg_write = 1'b1; ctrl.alu_b_src = 1'b1; ctrl.alu_control = ALU_PASSB; end
      OP_AUIPC:  begin ctrl.reg_write = 1'b1; ctrl.alu_b_src = 1'b1; ctrl.rd_src = 1'b1; end
      OP_JAL:    begin ctrl.reg_write = 1'b1; ctrl.result_src = RS_PC4; ctrl.jump = JMP_JAL; end
      OP_JALR:   begin
        ctrl.reg_write = 1'b1; ctrl.result_src = RS_PC4; ctrl.jump = JMP_JALR; ctrl.alu_b_src = 1'b1;
      end
      OP_BRANCH: begin ctrl.branch = 1'b1; ctrl.alu_control = ALU_SUB; end
      OP_LOAD:   begin
        ctrl.reg_write = 1'b1; ctrl.result_src = RS_MEM; ctrl.alu_b_src = 1'b1;
        ctrl.byte_sel  = (f3[1:0] == 2'b00) ? 4'b0001 : (f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
      end
      OP_STORE:  begin
        ctrl.mem_write = 1'b1; ctrl.alu_b_src = 1'b1;
        ctrl.byte_sel  = (f3[1:0] == 2'b00) ? 4'b0001 : (f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
      end
      // Only shifts read funct7[5] in the immediate form.
      OP_IMM:    begin
        ctrl.reg_write = 1'b1; ctrl.alu_b_src = 1'b1; ctrl.alu_control = {(f3 == 3'b101) & instr[30], f3};
      end
      OP_OP:     begin ctrl.reg_write = 1'b1; ctrl.alu_control = {instr[30], f3}; end
      OP_FENCE, OP_SYSTEM: ;
      default:   illegal = 1'b1;
    endcase
    if (NREG <= 16 && (instr[24] | instr[19] | instr[11])) illegal = 1'b1;
    if (instr[11:7] == 5'd0) ctrl.reg_write = 1'b0;
    if (illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
    end
  end

endmodule

// File: rtl/riscv_id_hazard.sv
// rtl/riscv_id_hazard.sv - load-use hazard detect between the ID/EX load and the instruction in decode
module riscv_id_hazard
  import riscv_id_stage_pkg::*;
(
  input  logic        ex_valid,
  input  logic [1:0]  ex_result_src,
  input  logic [4:0]  ex_rd_addr,
  input  logic        if_valid,
  input  logic [31:0] instr,
  output logic        hazard
);

  fmt_e fmt;
  logic uses_rs2;
  logic rs1_hit;
  logic rs2_hit;

  assign fmt      = op_format(instr[6:0]);
  assign uses_rs2 = (fmt == FMT_R) | (fmt == FMT_S) | (fmt == FMT_B);
  assign rs1_hit  = (ex_rd_addr == instr[19:15]);
  assign rs2_hit  = uses_rs2 & (ex_rd_addr == instr[24:20]);

  assign hazard = ex_valid & if_valid & (ex_result_src == RS_MEM) & (ex_rd_addr != 5'd0)
                & (rs1_hit | rs2_hit);

endmodule

// File: rtl/riscv_id_regfile.sv
// rtl/riscv_id_regfile.sv - NREG x XLEN register file, combinational reads with optional write-back bypass
module riscv_id_regfile
  import riscv_id_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_req,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem [NREG];
  logic            wr_en;

  assign wr_en = wr_req & (wr_addr != 5'd0) & (int'(wr_addr) < NREG);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Addresses beyond NREG read as zero; the decoder flags them illegal anyway.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= NREG) return '0;
    if (WB_BYPASS != 0 && wr_en && a == wr_addr) return wr_data;
    return mem[a[AW-1:0]];
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

endmodule

// File: rtl/riscv_id_stage.sv
// rtl/riscv_id_stage.sv - decode stage: regfile, control, immediates, load-use bubbles and ID/EX register
module riscv_id_stage
  import riscv_id_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NREG        = 32,
  parameter int WB_BYPASS   = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_if_valid,
  input  logic [XLEN-1:0]        i_if_instr,
  input  logic [XLEN-1:0]        i_if_pc,
  output logic                   o_if_ready,
  input  logic                   i_wb_reg_write,
  input  logic [4:0]             i_wb_rd_addr,
  input  logic [XLEN-1:0]        i_wb_rd_data,
  input  logic                   i_ex_ready,
  output logic                   o_ex_valid,
  output logic [XLEN-1:0]        o_ex_pc,
  output logic [XLEN-1:0]        o_ex_rs1_data,
  output logic [XLEN-1:0]        o_ex_rs2_data,
  output logic [XLEN-1:0]        o_ex_imm,
  output logic [4:0]             o_ex_rs1_addr,
  output logic [4:0]             o_ex_rs2_addr,
  output logic [4:0]             o_ex_rd_addr,
  output logic [2:0]             o_ex_funct3,
  output logic [16:0]            o_ex_ctrl,
  output logic                   o_ex_illegal,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  logic [31:0]     instr;
  logic            adv;
  logic            hazard;
  logic            accept;
  ctrl_t           dec_ctrl;
  ctrl_t           ex_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  assign instr   = i_if_instr[31:0];
  assign ex_ctrl = ctrl_t'(o_ex_ctrl);

  riscv_id_regfile #(.XLEN(XLEN), .NREG(NREG), .WB_BYPASS(WB_BYPASS)) u_regfile (
    .clk      (i_clk),
    .rst      (i_rst),
    .rs1_addr (instr[19:15]),
    .rs2_addr (instr[24:20]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_req   (i_wb_reg_write),
    .wr_addr  (i_wb_rd_addr),
    .wr_data  (i_wb_rd_data)
  );

  riscv_id_control #(.XLEN(XLEN), .NREG(NREG)) u_control (
    .instr   (instr),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  riscv_id_hazard u_hazard (
    .ex_valid      (o_ex_valid),
    .ex_result_src (ex_ctrl.result_src),
    .ex_rd_addr    (o_ex_rd_addr),
    .if_valid      (i_if_valid),
    .instr         (instr),
    .hazard        (hazard)
  );

  // A flushed instruction is still consumed so IF can move to the redirect target.
  assign adv        = ~o_ex_valid | i_ex_ready;
  assign o_if_ready = adv & (~hazard | i_flush);
  assign accept     = i_if_valid & o_if_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ex_valid    <= 1'b0;
      o_ex_pc       <= '0;
      o_ex_rs1_data <= '0;
      o_ex_rs2_data <= '0;
      o_ex_imm      <= '0;
      o_ex_rs1_addr <= '0;
      o_ex_rs2_addr <= '0;
      o_ex_rd_addr  <= '0;
      o_ex_funct3   <= '0;
      o_ex_ctrl     <= '0;
      o_ex_illegal  <= 1'b0;
      o_stall_cnt   <= '0;
    end else begin
      if (adv) begin
        o_ex_valid <= i_if_valid & ~hazard & ~i_flush;
        if (accept) begin
          o_ex_pc       <= i_if_pc;
          o_ex_rs1_data <= rs1_data;
          o_ex_rs2_data <= rs2_data;
          o_ex_imm      <= dec_imm;
          o_ex_rs1_addr <= instr[19:15];
          o_ex_rs2_addr <= instr[24:20];
          o_ex_rd_addr  <= instr[11:7];
          o_ex_funct3   <= instr[14:12];
          o_ex_ctrl     <= dec_ctrl;
          o_ex_illegal  <= dec_illegal;
        end
      end
      if (hazard & adv & ~i_flush & ~&o_stall_cnt) o_stall_cnt <= o_stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_riscv_id_stage.sv
// tb/tb_riscv_id_stage.sv - directed scoreboard bench over default, no-bypass and RV32E decode stages
module tb_riscv_id_stage;

  localparam logic [6:0] T_OP   = 7'b0110011;
  localparam logic [6:0] T_IMM  = 7'b0010011;
  localparam logic [6:0] T_LOAD = 7'b0000011;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, wb_we, ex_ready;
  logic [31:0] if_instr, if_pc, wb_data;
  logic [4:0]  wb_addr;

  logic        if_ready   [3];
  logic        ex_valid   [3];
  logic        ex_illegal [3];
  logic [31:0] ex_pc      [3];
  logic [31:0] ex_rs1     [3];
  logic [31:0] ex_rs2     [3];
  logic [31:0] ex_imm     [3];
  logic [4:0]  ex_rs1a    [3];
  logic [4:0]  ex_rs2a    [3];
  logic [4:0]  ex_rd      [3];
  logic [2:0]  ex_f3      [3];
  logic [16:0] ex_ctrl    [3];
  logic [15:0] stall_cnt  [3];

  always #5 clk = ~clk;

  // Instance 0: default, 1: WB_BYPASS=0, 2: NREG=16 (RV32E).
  for (genvar g = 0; g < 3; g++) begin : g_dut
    riscv_id_stage #(.XLEN(32), .NREG(g == 2 ? 16 : 32), .WB_BYPASS(g == 1 ? 0 : 1), .STALL_CNT_W(16)) u_dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_flush        (flush),
      .i_if_valid     (if_valid),
      .i_if_instr     (if_instr),
      .i_if_pc        (if_pc),
      .o_if_ready     (if_ready[g]),
      .i_wb_reg_write (wb_we),
      .i_wb_rd_addr   (wb_addr),
      .i_wb_rd_data   (wb_data),
      .i_ex_ready     (ex_ready),
      .o_ex_valid     (ex_valid[g]),
      .o_ex_pc        (ex_pc[g]),
      .o_ex_rs1_data  (ex_rs1[g]),
      .o_ex_rs2_data  (ex_rs2[g]),
      .o_ex_imm       (ex_imm[g]),
      .o_ex_rs1_addr  (ex_rs1a[g]),
      .o_ex_rs2_addr  (ex_rs2a[g]),
      .o_ex_rd_addr   (ex_rd[g]),
      .o_ex_funct3    (ex_f3[g]),
      .o_ex_ctrl      (ex_ctrl[g]),
      .o_ex_illegal   (ex_illegal[g]),
      .o_stall_cnt    (stall_cnt[g])
    );
  end

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rs1a, rd;
    logic        rw, ill, imm_chk;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] rf_m [32];
  int          vec_cnt = 0;
  int          err_cnt = 0;

  // Reference register file for the default instance.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_m[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      rf_m[wb_addr] <= wb_data;
    end
  end

  function automatic logic [31:0] rd_m(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (wb_we && wb_addr == a) return wb_data;
    return rf_m[a];
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, T_OP};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = ins;
    #1;
  endtask

  task automatic push_exp(input logic [31:0] imm, input logic rw, input logic ill, input logic imm_chk);
    exp_t e;
    e.pc = if_pc;  e.rs1 = rd_m(if_instr[19:15]);  e.rs2 = rd_m(if_instr[24:20]);
    e.imm = imm;   e.rs1a = if_instr[19:15];       e.rd = if_instr[11:7];
    e.rw = rw;     e.ill = ill;                    e.imm_chk = imm_chk;
    sb.push_back(e);
  endtask

  task automatic check_out;
    exp_t e;
    chk("ex_valid", ex_valid[0], 1);
    chk("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ex_pc", ex_pc[0], e.pc);
      chk("ex_rs1_data", ex_rs1[0], e.rs1);
      chk("ex_rs2_data", ex_rs2[0], e.rs2);
      chk("ex_rs1_addr", ex_rs1a[0], e.rs1a);
      chk("ex_rd_addr", ex_rd[0], e.rd);
      chk("ctrl_reg_write", ex_ctrl[0][0], e.rw);
      chk("ex_illegal", ex_illegal[0], e.ill);
      if (e.imm_chk) chk("ex_imm", ex_imm[0], e.imm);
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] imm,
                       input logic rw, input logic ill, input logic imm_chk);
    drive(pc, ins);
    chk("if_ready_issue", if_ready[0], 1);
    push_exp(imm, rw, ill, imm_chk);
    tick;
    if_valid = 1'b0;
    check_out();
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick;
    wb_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; wb_we = 1'b0; ex_ready = 1'b1;
    if_instr = '0; if_pc = '0; wb_data = '0; wb_addr = '0;
    tick; tick;
    chk("rst_ex_valid", ex_valid[0], 0);
    chk("rst_ex_pc", ex_pc[0], 0);
    chk("rst_ex_ctrl", ex_ctrl[0], 0);
    chk("rst_stall_cnt", stall_cnt[0], 0);
    chk("rst_if_ready", if_ready[0], 1);
    rst = 1'b0;

    wb_write(5'd5, 32'h1234);
    wb_write(5'd1, 32'h100);
    wb_write(5'd2, 32'h22);
    wb_write(5'd7, 32'h0BAD);

    issue(32'h40, enc_r(5'd0, 5'd5, 5'd6), 32'h0, 1'b1, 1'b0, 1'b1);
    chk("add_rs1_data", ex_rs1[0], 32'h1234);

    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD;
    issue(32'h44, enc_i(12'd1, 5'd7, 3'b000, 5'd8, T_IMM), 32'h1, 1'b1, 1'b0, 1'b1);
    wb_we = 1'b0;
    chk("bypass_rs1", ex_rs1[0], 32'hDEAD);
    chk("nobypass_rs1", ex_rs1[1], 32'h0BAD);

    issue(32'h48, enc_i(12'd0, 5'd1, 3'b010, 5'd9, T_LOAD), 32'h0, 1'b1, 1'b0, 1'b1);
    chk("lw_result_src", ex_ctrl[0][2:1], 2'b01);
    issue(32'h4C, enc_i(12'd9, 5'd1, 3'b000, 5'd3, T_IMM), 32'h9, 1'b1, 1'b0, 1'b1);
    chk("no_stall_itype_rs2", stall_cnt[0], 0);

    issue(32'h50, enc_i(12'd0, 5'd1, 3'b010, 5'd9, T_LOAD), 32'h0, 1'b1, 1'b0, 1'b1);
    drive(32'h54, enc_r(5'd2, 5'd9, 5'd10));
    chk("loaduse_if_ready", if_ready[0], 0);
    tick;
    chk("bubble_ex_valid", ex_valid[0], 0);
    chk("after_bubble_if_ready", if_ready[0], 1);
    push_exp(32'h0, 1'b1, 1'b0, 1'b1);
    tick;
    if_valid = 1'b0;
    check_out();
    chk("stall_cnt_one", stall_cnt[0], 1);

    issue(32'h58, enc_i(12'd7, 5'd0, 3'b000, 5'd11, T_IMM), 32'h7, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    drive(32'h5C, enc_r(5'd6, 5'd5, 5'd12));
    chk("flush_if_ready", if_ready[0], 1);
    chk("flush_ex_pc_held", ex_pc[0], 32'h58);
    tick;
    flush = 1'b0; if_valid = 1'b0;
    chk("flush_ex_valid", ex_valid[0], 0);
    chk("flush_stall_cnt", stall_cnt[0], 1);

    issue(32'h60, enc_i(12'd2, 5'd5, 3'b000, 5'd13, T_IMM), 32'h2, 1'b1, 1'b0, 1'b1);
    ex_ready = 1'b0;
    drive(32'h64, enc_r(5'd5, 5'd5, 5'd14));
    chk("exstall_if_ready", if_ready[0], 0);
    tick;
    chk("exstall_ex_valid", ex_valid[0], 1);
    chk("exstall_ex_pc", ex_pc[0], 32'h60);
    chk("exstall_ex_imm", ex_imm[0], 32'h2);
    chk("exstall_ex_rd", ex_rd[0], 13);
    chk("exstall_if_ready2", if_ready[0], 0);
    rst = 1'b1;
    tick;
    rst = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    chk("midrst_ex_valid", ex_valid[0], 0);
    chk("midrst_stall_cnt", stall_cnt[0], 0);
    chk("midrst_ex_pc", ex_pc[0], 0);
    chk("midrst_ex_ctrl", ex_ctrl[0], 0);

    issue(32'h70, enc_i(12'd0, 5'd5, 3'b000, 5'd15, T_IMM), 32'h0, 1'b1, 1'b0, 1'b1);
    chk("rf_cleared_rs1", ex_rs1[0], 0);
    wb_write(5'd0, 32'hFFFF);
    issue(32'h74, enc_i(12'd0, 5'd0, 3'b000, 5'd16, T_IMM), 32'h0, 1'b1, 1'b0, 1'b1);

    issue(32'h78, enc_r(5'd2, 5'd1, 5'd17), 32'h0, 1'b1, 1'b0, 1'b1);
    chk("rv32e_ex_valid", ex_valid[2], 1);
    chk("rv32e_illegal", ex_illegal[2], 1);
    chk("rv32e_reg_write", ex_ctrl[2][0], 0);
    issue(32'h7C, enc_i(12'd5, 5'd1, 3'b000, 5'd0, T_IMM), 32'h5, 1'b0, 1'b0, 1'b1);
    issue(32'h80, 32'h00000F7F, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
